systolic_feed_ctrl: RTL and testbench

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

---
 rtl/systolic_feed_ctrl.sv | 179 +++++++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_ctrl.sv
// Operand feeder for an N x N systolic array: fetches K A/B vector pairs and skews lane i by i cycles.
// Optional WAIT-state watchdog is built only when SYSTOLIC_FEED_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module systolic_feed_ctrl #(
  parameter int DBITS   = 16,
  parameter int N       = 4,
  parameter int K       = 3,
  parameter int TIMEOUT = 64,
  localparam int AW     = (K > 1) ? $clog2(K) : 1
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               START,
  output logic               RD_EN,
  output logic [AW-1:0]      RD_ADDR,
  input  logic [N*DBITS-1:0] A_RDATA,
  input  logic [N*DBITS-1:0] B_RDATA,
  output logic [N*DBITS-1:0] ROW_DATA,
  output logic [N-1:0]       ROW_VALID,
  output logic [N*DBITS-1:0] COL_DATA,
  output logic [N-1:0]       COL_VALID,
  input  logic               PE_LAST_VALID,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rvld_q;
  logic          wd_expire;

  if (N < 1 || K < 1 || DBITS < 1 || TIMEOUT < 1) begin : g_param_check
    $error("systolic_feed_ctrl: N, K, DBITS and TIMEOUT must be positive");
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: begin
        if (addr_q == AW'(K - 1)) begin
          state_d = WAIT;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + AW'(1);
        end
      end
      WAIT: begin
        if (PE_LAST_VALID)  state_d = FIN;
        else if (wd_expire) state_d = IDLE;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    RD_EN = 1'b0;
    BUSY  = 1'b0;
    DONE  = 1'b0;
    case (state_q)
      FETCH: begin
        RD_EN = 1'b1;
        BUSY  = 1'b1;
      end
      WAIT:    BUSY = 1'b1;
      FIN: begin
        BUSY = 1'b1;
        DONE = 1'b1;
      end
      default: ;
    endcase
  end

  // addr_q returns to zero on leaving FETCH, so it is a clean address outside reads too
  assign RD_ADDR = addr_q;

`ifdef SYSTOLIC_FEED_TIMEOUT_EN
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  assign wd_expire = (state_q == WAIT) && !PE_LAST_VALID && (wd_q == WW'(TIMEOUT - 1));

  always_comb begin
    wd_d  = '0;
    err_d = err_q;
    if (state_q == WAIT)             wd_d  = wd_q + WW'(1);
    if (state_q == IDLE && START)    err_d = 1'b0;
    else if (wd_expire)              err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign wd_expire = 1'b0;
  assign ERR       = 1'b0;
`endif

  // Stage 0: read data is valid the cycle after RD_EN; gate it to zero otherwise
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rvld_q <= 1'b0;
    else       rvld_q <= RD_EN;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DBITS-1:0] a_s, b_s;

    assign a_s = rvld_q ? A_RDATA[gi*DBITS +: DBITS] : '0;
    assign b_s = rvld_q ? B_RDATA[gi*DBITS +: DBITS] : '0;

    if (gi == 0) begin : g_direct
      assign ROW_DATA[gi*DBITS +: DBITS] = a_s;
      assign COL_DATA[gi*DBITS +: DBITS] = b_s;
      assign ROW_VALID[gi]               = rvld_q;
      assign COL_VALID[gi]               = rvld_q;
    end else begin : g_skew
      logic [DBITS-1:0] a_q [gi];
      logic [DBITS-1:0] b_q [gi];
      logic             v_q [gi];

      // Shifts in every state so trailing lanes drain after FETCH ends
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          for (int s = 0; s < gi; s++) begin
            a_q[s] <= '0;
            b_q[s] <= '0;
            v_q[s] <= 1'b0;
          end
        end else begin
          a_q[0] <= a_s;
          b_q[0] <= b_s;
          v_q[0] <= rvld_q;
          for (int s = 1; s < gi; s++) begin
            a_q[s] <= a_q[s-1];
            b_q[s] <= b_q[s-1];
            v_q[s] <= v_q[s-1];
          end
        end
      end

      assign ROW_DATA[gi*DBITS +: DBITS] = a_q[gi-1];
      assign COL_DATA[gi*DBITS +: DBITS] = b_q[gi-1];
      assign ROW_VALID[gi]               = v_q[gi-1];
      assign COL_VALID[gi]               = v_q[gi-1];
    end
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench for systolic_feed_ctrl (N=4, K=3, DBITS=16) with operand memory and 4x4 PE array models.
`timescale 1ns/1ps

module tb_systolic_feed_ctrl;
  localparam int DB = 16;
  localparam int N  = 4;
  localparam int K  = 3;
  localparam int AW = 2;
`ifdef SYSTOLIC_FEED_TIMEOUT_EN
  localparam int TO = 8;
  localparam int P  = 10;
`else
  localparam int TO = 64;
  localparam int P  = 12;
`endif

  logic CLK = 1'b0;
  logic RSTN, START, RD_EN, BUSY, DONE, ERR, PE_LAST_VALID;
  logic [AW-1:0] RD_ADDR;
  logic [N*DB-1:0] A_RDATA, B_RDATA, ROW_DATA, COL_DATA;
  logic [N-1:0] ROW_VALID, COL_VALID;
  logic plv_tb, use_pe, e2e;

  int total = 0;
  int bad   = 0;

  logic [DB-1:0] rowq [N][$];
  logic [DB-1:0] colq [N][$];

  logic [DB-1:0] pa [N][N];
  logic [DB-1:0] pb [N][N];
  logic pav [N][N];
  logic pbv [N][N];
  logic pov [N][N];
  int pacc [N][N];
  int pcnt [N][N];
  int pod  [N][N];

  systolic_feed_ctrl #(.DBITS(DB), .N(N), .K(K), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
    .A_RDATA(A_RDATA), .B_RDATA(B_RDATA), .ROW_DATA(ROW_DATA), .ROW_VALID(ROW_VALID),
    .COL_DATA(COL_DATA), .COL_VALID(COL_VALID), .PE_LAST_VALID(PE_LAST_VALID),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  assign PE_LAST_VALID = use_pe ? pov[N-1][N-1] : plv_tb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      rowq[i].delete();
      colq[i].delete();
    end
  endtask

  function automatic int sb_size();
    int s = 0;
    for (int i = 0; i < N; i++) s += rowq[i].size() + colq[i].size();
    return s;
  endfunction

  // Operand memory: one-cycle read latency; expected lane values are queued as reads are issued
  always @(posedge CLK) begin
    logic [DB-1:0] av, bv;
    if (RD_EN) begin
      for (int i = 0; i < N; i++) begin
        av = e2e ? DB'(2) : DB'(16 * int'(RD_ADDR) + i);
        bv = e2e ? DB'(2) : DB'(256 + 16 * int'(RD_ADDR) + i);
        A_RDATA[i*DB +: DB] <= av;
        B_RDATA[i*DB +: DB] <= bv;
        rowq[i].push_back(av);
        colq[i].push_back(bv);
      end
    end else begin
      A_RDATA <= {N{16'hBEEF}};
      B_RDATA <= {N{16'hCAFE}};
    end
  end

  always @(negedge CLK) begin
    logic [DB-1:0] e;
    for (int i = 0; i < N; i++) begin
      if (ROW_VALID[i]) begin
        if (rowq[i].size() == 0) chk("row_unexpected", 1, 0);
        else begin
          e = rowq[i].pop_front();
          chk("row_data", ROW_DATA[i*DB +: DB], e);
        end
      end else chk("row_zero", ROW_DATA[i*DB +: DB], 0);
      if (COL_VALID[i]) begin
        if (colq[i].size() == 0) chk("col_unexpected", 1, 0);
        else begin
          e = colq[i].pop_front();
          chk("col_data", COL_DATA[i*DB +: DB], e);
        end
      end else chk("col_zero", COL_DATA[i*DB +: DB], 0);
    end
  end

  // Behavioural 4x4 output-stationary PE array: A flows right, B flows down, K-deep accumulate
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pa[i][j] <= '0; pb[i][j] <= '0; pav[i][j] <= 1'b0; pbv[i][j] <= 1'b0;
          pov[i][j] <= 1'b0; pacc[i][j] <= 0; pcnt[i][j] <= 0; pod[i][j] <= 0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin : pe_cell
          logic [DB-1:0] ai, bi;
          logic avi, bvi;
          int prod;
          if (j == 0) begin
            ai = ROW_DATA[i*DB +: DB]; avi = ROW_VALID[i];
          end else begin
            ai = pa[i][j-1]; avi = pav[i][j-1];
          end
          if (i == 0) begin
            bi = COL_DATA[j*DB +: DB]; bvi = COL_VALID[j];
          end else begin
            bi = pb[i-1][j]; bvi = pbv[i-1][j];
          end
          pa[i][j] <= ai; pav[i][j] <= avi;
          pb[i][j] <= bi; pbv[i][j] <= bvi;
          pov[i][j] <= 1'b0;
          if (avi && bvi) begin
            prod = int'(ai) * int'(bi);
            if (pcnt[i][j] == K - 1) begin
              pod[i][j] <= pacc[i][j] + prod;
              pov[i][j] <= 1'b1;
              pacc[i][j] <= 0;
              pcnt[i][j] <= 0;
            end else begin
              pacc[i][j] <= pacc[i][j] + prod;
              pcnt[i][j] <= pcnt[i][j] + 1;
            end
          end
        end
    end
  end

  typedef struct {
    logic         start;
    logic         plv;
    logic         rd_en;
    logic [1:0]   addr;
    logic         busy;
    logic         done;
    logic [N-1:0] rv;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t tbl[$];
    bit found;
    int nov, ov33, done_c, ndone;

    tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0001});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0011});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0111});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1110});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1100});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1000});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000});
    for (int c = 9; c < P; c++)
      tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 4'b0000});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0001});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0011});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0111});

    RSTN = 1'b0; START = 1'b0; plv_tb = 1'b0; use_pe = 1'b0; e2e = 1'b0;
    #1;
    chk("rst_rd_en", RD_EN, 0);
    chk("rst_rd_addr", RD_ADDR, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_row_valid", ROW_VALID, 0);
    chk("rst_col_valid", COL_VALID, 0);
    step(); step();
    RSTN = 1'b1;
    step();

    // Pass with START ignored mid-pass, completion, and back-to-back restart
    for (int k = 0; k < tbl.size(); k++) begin
      START  = tbl[k].start;
      plv_tb = tbl[k].plv;
      chk("seq_rd_en", RD_EN, tbl[k].rd_en);
      chk("seq_rd_addr", RD_ADDR, tbl[k].addr);
      chk("seq_busy", BUSY, tbl[k].busy);
      chk("seq_done", DONE, tbl[k].done);
      chk("seq_err", ERR, 0);
      chk("seq_row_valid", ROW_VALID, tbl[k].rv);
      chk("seq_col_valid", COL_VALID, tbl[k].rv);
      step();
    end
    START = 1'b0; plv_tb = 1'b0;
    repeat (3) step();
    plv_tb = 1'b1;
    step();
    plv_tb = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 5 && !found; w++) begin
      if (DONE) found = 1'b1;
      else step();
    end
    chk("pass2_done_seen", found, 1);
    step(); step();
    chk("pass_sb_empty", sb_size(), 0);

    // Reset asserted mid-FETCH
    START = 1'b1; step();
    START = 1'b0; step();
    chk("mid_pre_rd_en", RD_EN, 1);
    #2 RSTN = 1'b0;
    #1;
    chk("mid_rd_en", RD_EN, 0);
    chk("mid_rd_addr", RD_ADDR, 0);
    chk("mid_busy", BUSY, 0);
    chk("mid_done", DONE, 0);
    chk("mid_err", ERR, 0);
    chk("mid_row_valid", ROW_VALID, 0);
    chk("mid_col_valid", COL_VALID, 0);
    chk("mid_row_data", ROW_DATA, 0);
    chk("mid_col_data", COL_DATA, 0);
    flush();
    step(); step();
    RSTN = 1'b1;
    for (int c = 0; c < 20; c++) begin
      plv_tb = (c % 5 == 2);
      chk("post_rst_done", DONE, 0);
      chk("post_rst_busy", BUSY, 0);
      step();
    end
    plv_tb = 1'b0;
    chk("post_rst_sb", sb_size(), 0);

`ifdef SYSTOLIC_FEED_TIMEOUT_EN
    // Watchdog: no PE_LAST_VALID for TO WAIT cycles
    START = 1'b1; step();
    START = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      chk("wd_done_low", DONE, 0);
      chk("wd_busy_high", BUSY, 1);
      chk("wd_err_low", ERR, 0);
      step();
    end
    chk("wd_busy_drop", BUSY, 0);
    chk("wd_err_set", ERR, 1);
    chk("wd_no_done", DONE, 0);
    step();
    chk("wd_err_sticky", ERR, 1);
    START = 1'b1; step();
    START = 1'b0;
    chk("wd_err_cleared", ERR, 0);
    chk("wd_restart_busy", BUSY, 1);
    repeat (3) step();
    plv_tb = 1'b1; step();
    plv_tb = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 5 && !found; w++) begin
      if (DONE) found = 1'b1;
      else step();
    end
    chk("wd_restart_done", found, 1);
    step(); step();
`endif

    // End-to-end through the PE array model, all operands = 2
    RSTN = 1'b0; step();
    RSTN = 1'b1; step();
    flush();
    e2e = 1'b1; use_pe = 1'b1;
    nov = 0; ov33 = -1; done_c = -1; ndone = 0;
    START = 1'b1;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (pov[i][j]) begin
            chk("pe_out_data", pod[i][j], 12);
            nov++;
            if (i == N - 1 && j == N - 1) ov33 = c;
          end
      if (DONE) begin
        done_c = c;
        ndone++;
      end
      step();
      START = 1'b0;
    end
    chk("e2e_pe_count", nov, N * N);
    chk("e2e_done_once", ndone, 1);
    chk("e2e_done_after_last", done_c, ov33 + 1);
    chk("e2e_sb_empty", sb_size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
